// File: rtl/eqc_pkg.sv
// Shared types and constants for the equivalence-check sequencer.
//   eqc_state_e       - sequencer FSM states
//   LFSR_POLY         - Galois taps for x^16+x^14+x^13+x^11+1
//   LFSR_DEFAULT_SEED - reset/start value of the stimulus LFSR
//   lfsr_advance()    - one Galois step of the 16-bit LFSR
package eqc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StSettle,
        StCompare,
        StDone
    } eqc_state_e;

    localparam logic [15:0] LFSR_POLY         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Right-shifting Galois form: the bit shifted out selects the tap XOR.
    function automatic logic [15:0] lfsr_advance(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR used as the reproducible stimulus source.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, loads seed
//   load - reload seed (start of a run)
//   seed - value loaded on rst/load
//   step - advance one position
//   q    - current LFSR state
module lfsr16
    import eqc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] q_q;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            q_q <= seed;
        end else if (step) begin
            q_q <= lfsr_advance(q_q);
        end
    end

    assign q = q_q;

endmodule

// File: rtl/equiv_check_sequencer.sv
// Drives a shared stimulus bus into a structural/behavioural DUT pair, waits a
// fixed settle time per vector, compares the two output buses and keeps a
// running mismatch record that ends in a pass/fail verdict.
//   clk, rst         - clock, synchronous active-high reset
//   start            - begin a run (only honoured when idle)
//   stim             - registered stimulus to both UUTs
//   beh_out, str_out - outputs of the behavioural / structural UUT
//   busy             - run in progress
//   done             - one-cycle pulse at end of run
//   pass             - last run completed with zero mismatches
//   vec_idx          - index of the vector currently on stim
//   mismatch_count   - mismatches in the current/last run
//   first_fail_*     - valid flag, index and stimulus of the first mismatch
module equiv_check_sequencer
    import eqc_pkg::*;
#(
    parameter int unsigned N_IN          = 4,
    parameter int unsigned N_OUT         = 4,
    parameter int unsigned NUM_VECTORS   = 20,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] LFSR_SEED     = LFSR_DEFAULT_SEED,
    localparam int unsigned IDX_W  = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
    localparam int unsigned CNT_W  = $clog2(NUM_VECTORS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [N_IN-1:0]    stim,
    input  logic [N_OUT-1:0]   beh_out,
    input  logic [N_OUT-1:0]   str_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [IDX_W-1:0]   vec_idx,
    output logic [CNT_W-1:0]   mismatch_count,
    output logic               first_fail_valid,
    output logic [IDX_W-1:0]   first_fail_idx,
    output logic [N_IN-1:0]    first_fail_stim
);

    localparam int unsigned SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCNT_W-1:0] SETTLE_LAST =
        SCNT_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    eqc_state_e        state_q;
    logic [SCNT_W-1:0] settle_cnt_q;
    logic [N_IN-1:0]   stim_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [IDX_W-1:0]  vec_idx_q;
    logic [CNT_W-1:0]  count_q;
    logic              ff_valid_q;
    logic [IDX_W-1:0]  ff_idx_q;
    logic [N_IN-1:0]   ff_stim_q;

    logic [15:0] lfsr_q;
    logic        lfsr_load;
    logic        lfsr_step;
    logic        mismatch;
    logic        unused_lfsr;

    assign lfsr_load   = (state_q == StIdle) && start;
    assign lfsr_step   = (state_q == StCompare);
    assign mismatch    = (beh_out != str_out);
    assign unused_lfsr = ^lfsr_q;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (LFSR_SEED),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            settle_cnt_q <= '0;
            stim_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            vec_idx_q    <= '0;
            count_q      <= '0;
            ff_valid_q   <= 1'b0;
            ff_idx_q     <= '0;
            ff_stim_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StApply;
                        busy_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        vec_idx_q  <= '0;
                        count_q    <= '0;
                        ff_valid_q <= 1'b0;
                        ff_idx_q   <= '0;
                        ff_stim_q  <= '0;
                    end
                end
                StApply: begin
                    stim_q       <= lfsr_q[N_IN-1:0];
                    settle_cnt_q <= '0;
                    state_q      <= (SETTLE_CYCLES == 0) ? StCompare : StSettle;
                end
                StSettle: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_q <= StCompare;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SCNT_W'(1);
                    end
                end
                StCompare: begin
                    if (mismatch) begin
                        count_q <= count_q + CNT_W'(1);
                        if (!ff_valid_q) begin
                            ff_valid_q <= 1'b1;
                            ff_idx_q   <= vec_idx_q;
                            ff_stim_q  <= stim_q;
                        end
                    end
                    if (vec_idx_q == LAST_IDX) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        vec_idx_q <= vec_idx_q + IDX_W'(1);
                        state_q   <= StApply;
                    end
                end
                StDone: begin
                    // count_q already includes the final compare here
                    pass_q  <= (count_q == '0);
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stim             = stim_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign vec_idx          = vec_idx_q;
    assign mismatch_count   = count_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_idx   = ff_idx_q;
    assign first_fail_stim  = ff_stim_q;

endmodule

// File: tb/tb_equiv_check_sequencer.sv
module tb_equiv_check_sequencer;

    localparam int NV  = 20;
    localparam int SC  = 2;
    localparam int P   = SC + 2;
    localparam int LAT = NV * P + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, start2, inv2;
    logic [3:0] stim, beh_out, str_out;
    logic       busy, done, pass, ffv;
    logic [4:0] vec_idx, mcount, ffidx;
    logic [3:0] ffstim;

    logic [3:0] stim2, beh2, str2, ffstim2;
    logic       busy2, done2, pass2, ffv2;
    logic [0:0] vec_idx2, mcount2, ffidx2;

    int checks   = 0;
    int failures = 0;

    // UUT output models: a random behavioural truth table; structural differs by a mode mask
    logic [3:0] beh_table  [16];
    logic [3:0] mask_table [16];
    int         mode;

    function automatic logic [3:0] err_mask(input int m, input logic [3:0] s);
        case (m)
            1:       return (s == 4'h1) ? 4'b0001 : 4'b0000;
            2:       return 4'hF;
            3:       return mask_table[s];
            default: return 4'h0;
        endcase
    endfunction

    assign beh_out = beh_table[stim];
    assign str_out = beh_out ^ err_mask(mode, stim);
    assign beh2    = stim2;
    assign str2    = inv2 ? ~stim2 : stim2;

    equiv_check_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .stim             (stim),
        .beh_out          (beh_out),
        .str_out          (str_out),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .vec_idx          (vec_idx),
        .mismatch_count   (mcount),
        .first_fail_valid (ffv),
        .first_fail_idx   (ffidx),
        .first_fail_stim  (ffstim)
    );

    equiv_check_sequencer #(
        .NUM_VECTORS   (1),
        .SETTLE_CYCLES (0)
    ) dut_min (
        .clk              (clk),
        .rst              (rst),
        .start            (start2),
        .stim             (stim2),
        .beh_out          (beh2),
        .str_out          (str2),
        .busy             (busy2),
        .done             (done2),
        .pass             (pass2),
        .vec_idx          (vec_idx2),
        .mismatch_count   (mcount2),
        .first_fail_valid (ffv2),
        .first_fail_idx   (ffidx2),
        .first_fail_stim  (ffstim2)
    );

    // Reference: stimulus sequence from the LFSR rule, then a per-run verdict
    logic [3:0] exp_stim [NV];
    int         exp_count, exp_ffidx;
    logic       exp_ffv, exp_pass;
    logic [3:0] exp_ffstim;
    logic [3:0] seen_stim [NV];
    logic [4:0] seen_idx  [NV];

    task automatic build_expected();
        logic [15:0] v;
        v = 16'hACE1;
        for (int k = 0; k < NV; k++) begin
            exp_stim[k] = v[3:0];
            v = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
        end
    endtask

    task automatic model_run();
        exp_count  = 0;
        exp_ffv    = 1'b0;
        exp_ffidx  = 0;
        exp_ffstim = 4'h0;
        for (int k = 0; k < NV; k++) begin
            if (err_mask(mode, exp_stim[k]) != 4'h0) begin
                if (!exp_ffv) begin
                    exp_ffv    = 1'b1;
                    exp_ffidx  = k;
                    exp_ffstim = exp_stim[k];
                end
                exp_count++;
            end
        end
        exp_pass = (exp_count == 0);
    endtask

    // Pulses start, samples stim/vec_idx mid-vector, returns the cycle done was seen
    // (start edge = cycle 1) or -1 on timeout. r1/r2: cycles at which start is re-pulsed.
    task automatic run_dut(input int r1, input int r2, output int done_cycle);
        int cyc;
        done_cycle = -1;
        for (int k = 0; k < NV; k++) begin
            seen_stim[k] = 4'hx;
            seen_idx[k]  = 5'hx;
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (done_cycle < 0 && cyc < LAT + 20) begin
            if (cyc >= 2 && (cyc - 2) % P == 0 && (cyc - 2) / P < NV) begin
                seen_stim[(cyc - 2) / P] = stim;
                seen_idx[(cyc - 2) / P]  = vec_idx;
            end
            if (done) done_cycle = cyc;
            start = (cyc == r1 || cyc == r2);
            if (done_cycle < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({stim, busy, done, pass, vec_idx, mcount, ffv, ffidx, ffstim} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got stim=%h busy=%b done=%b pass=%b idx=%0d cnt=%0d ffv=%b ffidx=%0d ffstim=%h, want all 0",
                     stim, busy, done, pass, vec_idx, mcount, ffv, ffidx, ffstim);
        end
        checks++;
        if ({stim2, busy2, done2, pass2, mcount2, ffv2} !== '0) begin
            failures++;
            $display("FAIL reset_min_outputs: got stim=%h busy=%b done=%b pass=%b, want 0",
                     stim2, busy2, done2, pass2);
        end
        rst = 1'b0;
    endtask

    task automatic test_equal();
        int dc;
        mode = 0;
        model_run();
        run_dut(0, 0, dc);
        checks++;
        if (dc !== LAT) begin
            failures++;
            $display("FAIL equal_latency: done at cycle %0d, want %0d", dc, LAT);
        end
        checks++;
        if (seen_stim[0] !== 4'h1) begin
            failures++;
            $display("FAIL equal_first_stim: got %h want 1", seen_stim[0]);
        end
        for (int k = 0; k < NV; k++) begin
            checks++;
            if (seen_stim[k] !== exp_stim[k] || seen_idx[k] !== 5'(k)) begin
                failures++;
                $display("FAIL equal_stim_seq[%0d]: got stim=%h idx=%0d want stim=%h idx=%0d",
                         k, seen_stim[k], seen_idx[k], exp_stim[k], k);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL equal_busy_in_done: got %b want 0", busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({done, busy, pass, mcount, ffv} !== {1'b0, 1'b0, 1'b1, 5'd0, 1'b0}) begin
            failures++;
            $display("FAIL equal_verdict: got done=%b busy=%b pass=%b cnt=%0d ffv=%b, want 0 0 1 0 0",
                     done, busy, pass, mcount, ffv);
        end
        checks++;
        if (stim !== exp_stim[NV-1] || vec_idx !== 5'(NV - 1)) begin
            failures++;
            $display("FAIL equal_hold: got stim=%h idx=%0d want stim=%h idx=%0d",
                     stim, vec_idx, exp_stim[NV-1], NV - 1);
        end
    endtask

    task automatic test_single_fail();
        int dc;
        mode = 1;
        model_run();
        run_dut(0, 0, dc);
        @(negedge clk);
        checks++;
        if (ffidx !== 5'd0 || ffstim !== 4'h1 || ffv !== 1'b1) begin
            failures++;
            $display("FAIL single_first_fail: got v=%b idx=%0d stim=%h want v=1 idx=0 stim=1",
                     ffv, ffidx, ffstim);
        end
        checks++;
        if (mcount !== 5'(exp_count) || pass !== 1'b0 || dc !== LAT) begin
            failures++;
            $display("FAIL single_count: got cnt=%0d pass=%b done@%0d want cnt=%0d pass=0 done@%0d",
                     mcount, pass, dc, exp_count, LAT);
        end
    endtask

    task automatic test_inverted();
        int dc;
        mode = 2;
        model_run();
        run_dut(0, 0, dc);
        @(negedge clk);
        checks++;
        if (mcount !== 5'd20 || pass !== 1'b0 || ffidx !== 5'd0 || ffv !== 1'b1) begin
            failures++;
            $display("FAIL inverted_verdict: got cnt=%0d pass=%b ffidx=%0d ffv=%b want 20 0 0 1",
                     mcount, pass, ffidx, ffv);
        end
    endtask

    task automatic test_random_mask();
        int dc;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 16; i++) begin
                beh_table[i]  = 4'($urandom);
                mask_table[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            mode = 3;
            model_run();
            run_dut(0, 0, dc);
            @(negedge clk);
            checks++;
            if (mcount !== 5'(exp_count) || pass !== exp_pass || ffv !== exp_ffv ||
                ffidx !== 5'(exp_ffidx) || ffstim !== exp_ffstim || dc !== LAT) begin
                failures++;
                $display("FAIL random_run[%0d]: got cnt=%0d pass=%b ffv=%b ffidx=%0d ffstim=%h done@%0d want %0d %b %b %0d %h %0d",
                         it, mcount, pass, ffv, ffidx, ffstim, dc,
                         exp_count, exp_pass, exp_ffv, exp_ffidx, exp_ffstim, LAT);
            end
        end
    endtask

    task automatic test_start_ignored();
        int dc;
        mode = 1;
        model_run();
        run_dut(10, 40, dc);
        checks++;
        if (dc !== LAT) begin
            failures++;
            $display("FAIL restart_latency: done at cycle %0d, want %0d", dc, LAT);
        end
        for (int k = 0; k < NV; k++) begin
            checks++;
            if (seen_stim[k] !== exp_stim[k]) begin
                failures++;
                $display("FAIL restart_stim_seq[%0d]: got %h want %h", k, seen_stim[k], exp_stim[k]);
            end
        end
        @(negedge clk);
        checks++;
        if (mcount !== 5'(exp_count) || ffidx !== 5'd0) begin
            failures++;
            $display("FAIL restart_verdict: got cnt=%0d ffidx=%0d want %0d 0", mcount, ffidx, exp_count);
        end
    endtask

    task automatic test_midrun_reset();
        int dc;
        int waited;
        mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (vec_idx !== 5'd5 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (vec_idx !== 5'd5) begin
            failures++;
            $display("FAIL midrun_reach_idx5: got idx=%0d want 5", vec_idx);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({stim, busy, done, pass, vec_idx, mcount, ffv, ffidx, ffstim} !== '0) begin
            failures++;
            $display("FAIL midrun_reset_outputs: got stim=%h busy=%b idx=%0d cnt=%0d ffv=%b, want all 0",
                     stim, busy, vec_idx, mcount, ffv);
        end
        rst  = 1'b0;
        mode = 0;
        run_dut(0, 0, dc);
        checks++;
        if (dc !== LAT || seen_stim[0] !== 4'h1) begin
            failures++;
            $display("FAIL midrun_rerun: done@%0d first stim=%h want done@%0d stim=1",
                     dc, seen_stim[0], LAT);
        end
        for (int k = 0; k < NV; k++) begin
            checks++;
            if (seen_stim[k] !== exp_stim[k]) begin
                failures++;
                $display("FAIL midrun_stim_seq[%0d]: got %h want %h", k, seen_stim[k], exp_stim[k]);
            end
        end
    endtask

    task automatic test_min_config();
        int cyc;
        int dc;
        for (int pass_no = 0; pass_no < 2; pass_no++) begin
            inv2 = (pass_no == 0);
            @(negedge clk);
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            cyc    = 1;
            dc     = -1;
            while (dc < 0 && cyc < 20) begin
                if (cyc == 2) begin
                    checks++;
                    if (stim2 !== 4'h1) begin
                        failures++;
                        $display("FAIL min_stim: got %h want 1", stim2);
                    end
                end
                if (done2) dc = cyc;
                if (dc < 0) begin
                    @(negedge clk);
                    cyc++;
                end
            end
            checks++;
            if (dc !== 3) begin
                failures++;
                $display("FAIL min_latency: done at cycle %0d want 3", dc);
            end
            @(negedge clk);
            checks++;
            if (pass2 !== !inv2 || mcount2 !== 1'(inv2) || ffv2 !== inv2 ||
                ffstim2 !== (inv2 ? 4'h1 : 4'h0) || busy2 !== 1'b0) begin
                failures++;
                $display("FAIL min_verdict[%0d]: got pass=%b cnt=%0d ffv=%b ffstim=%h busy=%b",
                         pass_no, pass2, mcount2, ffv2, ffstim2, busy2);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        inv2   = 1'b0;
        mode   = 0;
        for (int i = 0; i < 16; i++) begin
            beh_table[i]  = 4'($urandom);
            mask_table[i] = 4'h0;
        end
        build_expected();
        test_reset();
        test_equal();
        test_single_fail();
        test_inverted();
        test_random_mask();
        test_start_ignored();
        test_midrun_reset();
        test_min_config();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
